seg_display_arbiter: RTL

- Shares the 6-digit seven-segment display path (seg_decoder per digit, then seg_scan) among three requesters, e.g. key counter, EEPROM status and error code.
- Grants ownership round-robin with a guaranteed minimum dwell per owner, so digits stay readable.
- Inserts a one-cycle blank gap on every ownership change.
- Emits a registered 24-bit digit bus (6 x 4-bit codes) for the downstream decoders.

---
 rtl/seg_display_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbitration for the shared 6-digit display bus
// Each owner keeps the display for at least HOLD_CYCLES; every handover passes through one blank cycle.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] req_data0,
  input  logic [23:0] req_data1,
  input  logic [23:0] req_data2,
  output logic [2:0]  gnt,
  output logic [1:0]  owner_id,
  output logic        disp_valid,
  output logic [23:0] disp_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [23:0]      BLANK_WORD = {6{BLANK_CODE}};

  function automatic logic [23:0] f_pick_data(input logic [1:0] idx, input logic [23:0] d0,
                                               input logic [23:0] d1, input logic [23:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  state_t           r_state;
  logic [2:0]       r_gnt;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic             r_valid;
  logic [23:0]      r_data;
  logic [CNT_W-1:0] r_dwell;

  state_t           w_nxt_state;
  logic [2:0]       w_nxt_gnt;
  logic [1:0]       w_nxt_owner;
  logic [1:0]       w_nxt_last;
  logic             w_nxt_valid;
  logic [23:0]      w_nxt_data;
  logic [CNT_W-1:0] w_nxt_dwell;

  logic [1:0]       w_c1;
  logic [1:0]       w_c2;
  logic [1:0]       w_pick;
  logic             w_any_req;
  logic             w_own_req;
  logic             w_others;
  logic             w_done;

  // Search order starts just after the previous owner, so it falls to lowest priority.
  always_comb begin
    w_c1   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_c2   = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_pick = r_last;
    if (req[w_c1])
      w_pick = w_c1;
    else if (req[w_c2])
      w_pick = w_c2;
  end

  assign w_any_req = |req;
  assign w_own_req = req[r_owner];
  assign w_others  = |(req & ~r_gnt);
  assign w_done    = (r_dwell == HOLD_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_valid = r_valid;
    w_nxt_data  = r_data;
    w_nxt_dwell = r_dwell;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_any_req) begin
          w_nxt_state = ST_GRANT;
          w_nxt_gnt   = 3'b001 << w_pick;
          w_nxt_owner = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_valid = 1'b1;
          w_nxt_data  = f_pick_data(w_pick, req_data0, req_data1, req_data2);
          w_nxt_dwell = '0;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_gnt   = 3'b000;
          w_nxt_valid = 1'b0;
          w_nxt_data  = BLANK_WORD;
          w_nxt_dwell = '0;
        end
      end
      ST_GRANT: begin
        // Once the dwell is served, any other waiting requester forces a handover.
        if (w_done && (!w_own_req || w_others)) begin
          w_nxt_state = ST_RELEASE;
          w_nxt_gnt   = 3'b000;
          w_nxt_valid = 1'b0;
          w_nxt_data  = BLANK_WORD;
        end else begin
          if (!w_done)
            w_nxt_dwell = r_dwell + CNT_W'(1);
          if (w_own_req)
            w_nxt_data = f_pick_data(r_owner, req_data0, req_data1, req_data2);
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_gnt   = 3'b000;
        w_nxt_valid = 1'b0;
        w_nxt_data  = BLANK_WORD;
        w_nxt_dwell = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_owner <= 2'd2;
      r_last  <= 2'd2;
      r_valid <= 1'b0;
      r_data  <= BLANK_WORD;
      r_dwell <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_valid <= w_nxt_valid;
      r_data  <= w_nxt_data;
      r_dwell <= w_nxt_dwell;
    end
  end

  assign gnt        = r_gnt;
  assign owner_id   = r_owner;
  assign disp_valid = r_valid;
  assign disp_data  = r_data;

endmodule
